// File: rtl/up_dn_counter_ctrl.sv
// Up/down counter controller.
// Drives an external 5-bit counter to a requested value, either by a
// direct load or by issuing single Up/Down pulses. Each pulse is
// followed by a compare cycle, so the controller always sees the
// counter's updated value. A step budget of 31 pulses guards against
// a counter that does not respond.
module up_dn_counter_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Cmd_Valid,
  input  logic       Cmd_Mode,
  input  logic [4:0] Target,
  output logic       Cmd_Ready,
  input  logic [4:0] Counter,
  input  logic       High,
  input  logic       Low,
  output logic       Load,
  output logic       Up,
  output logic       Down,
  output logic [4:0] IN,
  output logic       Done,
  output logic       Err,
  output logic [4:0] Step_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CMP     = 3'd2,
    S_STEP_UP = 3'd3,
    S_STEP_DN = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [4:0] STEP_MAX = 5'd31;

  state_t     state_q, state_d;
  logic [4:0] target_q, target_d;
  logic [4:0] step_cnt_q, step_cnt_d;
  logic       err_q, err_d;

  // High/Low are status-only; the 0..31 range makes them redundant here.
  logic unused_flags;
  assign unused_flags = High ^ Low;

  // State and command registers; reset aborts any command in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      target_q   <= 5'd0;
      step_cnt_q <= 5'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      step_cnt_q <= step_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept, load, compare-and-step, complete.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    step_cnt_d = step_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (Cmd_Valid) begin
          target_d   = Target;
          step_cnt_d = 5'd0;
          err_d      = 1'b0;
          state_d    = Cmd_Mode ? S_LOAD : S_CMP;
        end
      end
      S_LOAD: state_d = S_CMP;
      S_CMP: begin
        // Equality wins over the step budget so a target reached on the
        // 31st pulse still completes without error.
        if (Counter == target_q) begin
          state_d = S_DONE;
        end else if (step_cnt_q == STEP_MAX) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (Counter < target_q) begin
          state_d = S_STEP_UP;
        end else begin
          state_d = S_STEP_DN;
        end
      end
      S_STEP_UP, S_STEP_DN: begin
        step_cnt_d = step_cnt_q + 5'd1;
        state_d    = S_CMP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    Cmd_Ready = (state_q == S_IDLE);
    Load      = (state_q == S_LOAD);
    Up        = (state_q == S_STEP_UP);
    Down      = (state_q == S_STEP_DN);
    Done      = (state_q == S_DONE);
  end

  assign IN       = target_q;
  assign Err      = err_q;
  assign Step_Cnt = step_cnt_q;

endmodule

// File: doc/up_dn_counter_ctrl.md
UP_DN_COUNTER_CTRL -- requirements
Module: up_dn_counter_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports as listed.
REQ-002 CLK  input  1  rising-edge clock, shared with the controlled counter.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 Cmd_Valid  input  1  command request; held until accepted.
REQ-005 Cmd_Mode  input  1  0 = step to target via Up/Down pulses, 1 = direct load.
REQ-006 Target  input  5  requested counter value.
REQ-007 Cmd_Ready  output  1  high only in IDLE; a command is accepted on a rising edge when Cmd_Valid and Cmd_Ready are both high.
REQ-008 Counter  input  5  present value of the controlled counter.
REQ-009 High, Low  input  1 each  counter flags: 31 and 0 respectively.
REQ-010 Load, Up, Down  output  1 each  counter controls; registered, and at most one is high per cycle.
REQ-011 IN  output  5  counter load value; registered, equal to the latched target.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 Err  output  1  valid with Done; set when the target was not reached.
REQ-014 Step_Cnt  output  5  number of Up/Down pulses issued for the current or last command.

Function
REQ-015 SHALL implement the states IDLE, LOAD, CMP, STEP_UP, STEP_DN and DONE, with all outputs decoded from registered state (Moore).
REQ-016 IDLE: Cmd_Ready=1 and Load=Up=Down=Done=0; on command acceptance, latch Target into Target_q, clear Step_Cnt and Err, then go to LOAD if Cmd_Mode=1, else to CMP.
REQ-017 LOAD: Load=1 and IN=Target_q for exactly one cycle, then go to CMP.
REQ-018 CMP (all controls 0), evaluated in this priority order:
- Counter==Target_q -> DONE with Err=0.
- else Step_Cnt==31 -> DONE with Err=1.
- else Counter<Target_q -> STEP_UP.
- else -> STEP_DN.
REQ-019 STEP_UP asserts Up=1 and STEP_DN asserts Down=1, each for exactly one cycle; Step_Cnt increments by 1 at the exit edge; the next state is always CMP.
REQ-020 The counter updates at the edge ending a STEP_*/LOAD cycle, so CMP always sees the post-update value; one step costs 2 cycles and no overshoot is possible.
REQ-021 DONE: Done=1 for one cycle, Err holds its final value, then go to IDLE.
REQ-022 Step-mode latency with N=|Target-Counter| at acceptance: Done is high in cycle 2N+2 after the accepting edge (cycle 1 = first cycle after that edge).
REQ-023 Load-mode latency: Load is high in cycle 1 and Done in cycle 3, provided the counter loads correctly.
REQ-024 Cmd_Valid outside IDLE SHALL be ignored, with no queuing.
REQ-025 Target equal to Counter SHALL issue no pulses and complete with Done in cycle 2, Step_Cnt=0.
REQ-026 Step_Cnt SHALL never wrap; the Err abort in REQ-018 caps it at 31.
REQ-027 Step_Cnt and Err SHALL hold their values through IDLE until the next acceptance.
REQ-028 Comparisons SHALL be 5-bit unsigned.
REQ-029 High/Low are status inputs only; the bounds 0..31 make a Down at 0 or an Up at 31 unreachable while the counter is tracking.

Reset
REQ-030 RST=0 SHALL force, at any time including mid-command: state=IDLE, Cmd_Ready=1, Load=Up=Down=Done=Err=0, IN=0, Step_Cnt=0, Target_q=0.
REQ-031 After RST rises, the first command SHALL be accepted at the next edge where Cmd_Valid=1.
REQ-032 This block SHALL NOT reset the counter; a command aborted by reset produces no Done.

Verification
REQ-033 Reset during STEP_UP (Counter 4 -> 9, Step_Cnt=2) -> all controls 0 immediately, Cmd_Ready=1, Step_Cnt=0, no Done.
REQ-034 Counter=13, step mode, Target=10 -> Down pulses in cycles 2, 4 and 6, Done in cycle 8, Counter=10, Step_Cnt=3, Err=0.
REQ-035 Counter=31, load mode, Target=3 -> Load=1 with IN=3 in cycle 1, Done in cycle 3, Counter=3, Step_Cnt=0.
REQ-036 Counter=12, step mode, Target=12 -> no pulses, Done in cycle 2, Step_Cnt=0.
REQ-037 Counter=0, step mode, Target=31 -> 31 Up pulses, Done in cycle 64, High=1, Err=0, Step_Cnt=31.
REQ-038 Stuck counter model (ignores Up), Counter=0, Target=5 -> 31 Up pulses, then Done with Err=1 and Step_Cnt=31.
REQ-039 Cmd_Valid asserted during STEP_* -> ignored; the same command is accepted at the first edge after returning to IDLE.
